// File: rtl/plab4_net_router_output_ctrl_tdm.sv
// Ring-router output-port controller: round-robin arbitration over three input
// requests, time-division multiplexed between two security domains.
module plab4_net_router_output_ctrl_tdm #(
  parameter int p_slot_cycles = 4,
  parameter bit p_tdm_en      = 1'b1,
  localparam int c_slot_nbits = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reqs_p0,
  input  logic       reqs_p1,
  input  logic       reqs_p2,
  input  logic       domain_p0,
  input  logic       domain_p1,
  input  logic       domain_p2,
  output logic       grants_p0,
  output logic       grants_p1,
  output logic       grants_p2,
  output logic       out_val,
  input  logic       out_rdy,
  output logic [1:0] xbar_sel,
  output logic       cur_domain
);

  localparam logic [c_slot_nbits-1:0] c_slot_last = c_slot_nbits'(p_slot_cycles - 1);

  logic [c_slot_nbits-1:0] slot_cnt_q, slot_cnt_d;
  logic                    cur_dom_q, cur_dom_d;
  logic [1:0]              prio_d0_q, prio_d0_d;
  logic [1:0]              prio_d1_q, prio_d1_d;

  logic [2:0] reqs, doms, eligible;
  logic [1:0] ptr, winner;
  logic       xfer;

  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign reqs = {reqs_p2, reqs_p1, reqs_p0};
  assign doms = {domain_p2, domain_p1, domain_p0};

  // Requests from the domain that does not own the slot are invisible here.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      eligible[i] = reqs[i] & (!p_tdm_en || (doms[i] == cur_dom_q));
    end
  end

  always_comb begin
    ptr = (p_tdm_en && cur_dom_q) ? prio_d1_q : prio_d0_q;
    if (ptr == 2'd3) ptr = 2'd0;
  end

  always_comb begin
    logic [1:0] idx;
    logic       found;
    winner = 2'd0;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 3; k++) begin
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
      idx = mod3_inc(idx);
    end
  end

  assign out_val    = |eligible;
  assign xfer       = out_val & out_rdy;
  assign xbar_sel   = out_val ? winner : 2'd0;
  assign grants_p0  = xfer && (winner == 2'd0);
  assign grants_p1  = xfer && (winner == 2'd1);
  assign grants_p2  = xfer && (winner == 2'd2);
  assign cur_domain = cur_dom_q;

  always_comb begin
    prio_d0_d  = prio_d0_q;
    prio_d1_d  = prio_d1_q;
    slot_cnt_d = slot_cnt_q;
    cur_dom_d  = cur_dom_q;
    if (xfer) begin
      if (p_tdm_en && cur_dom_q) prio_d1_d = mod3_inc(winner);
      else                       prio_d0_d = mod3_inc(winner);
    end
    // Slot timing is free-running so traffic can never shift a domain boundary.
    if (!p_tdm_en) begin
      slot_cnt_d = '0;
      cur_dom_d  = 1'b0;
    end else if (slot_cnt_q == c_slot_last) begin
      slot_cnt_d = '0;
      cur_dom_d  = ~cur_dom_q;
    end else begin
      slot_cnt_d = slot_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q <= '0;
      cur_dom_q  <= 1'b0;
      prio_d0_q  <= 2'd0;
      prio_d1_q  <= 2'd0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      cur_dom_q  <= cur_dom_d;
      prio_d0_q  <= prio_d0_d;
      prio_d1_q  <= prio_d1_d;
    end
  end

endmodule
